// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: buffers stereo samples in a FIFO and shifts them out
// as I2S on AUD_DACDAT. AUD_BCLK and AUD_DACLRCK come from the codec and are
// resynchronised into the CLOCK_50 domain.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                  write_audio_out,
    output logic                  audio_out_allowed,
    input  logic                  clear_audio_out_memory,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic [15:0]           underflow_count
);

    localparam int                  CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0]    SLOT_BITS  = CNT_W'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] LEVEL_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        LEFT,
        RIGHT
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                    state, state_next;
    logic                      bclk_p0, bclk_p1, bclk_p2;
    logic                      lrck_p0, lrck_p1, lrck_smp;
    logic                      bclk_fall, lr_edge;
    logic                      frame_start, enter_right;
    logic                      push, pop, fifo_empty;
    logic [ADDR_WIDTH-1:0]     wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]       level_next;
    logic [2*DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0]   rd_data;
    logic [DATA_WIDTH-1:0]     hold_r, shift_reg;
    logic [CNT_W-1:0]          bit_cnt;
    logic                      shift_en;

    // sync stage boundary: codec clocks into the CLOCK_50 domain
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bclk_p0  <= 1'b0;
            bclk_p1  <= 1'b0;
            bclk_p2  <= 1'b0;
            lrck_p0  <= 1'b0;
            lrck_p1  <= 1'b0;
            lrck_smp <= 1'b0;
        end else begin
            bclk_p0 <= AUD_BCLK;
            bclk_p1 <= bclk_p0;
            bclk_p2 <= bclk_p1;
            lrck_p0 <= AUD_DACLRCK;
            lrck_p1 <= lrck_p0;
            if (bclk_fall) lrck_smp <= lrck_p1;
        end
    end

    assign bclk_fall = bclk_p2 & ~bclk_p1;
    assign lr_edge   = bclk_fall & (lrck_p1 != lrck_smp);

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= WAIT_SYNC;
        else         state <= state_next;
    end

    // FSM next state: frame changes only on a sampled LRCK edge
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        enter_right = 1'b0;
        if (lr_edge) begin
            case (state)
                WAIT_SYNC: if (!lrck_p1) begin
                    state_next  = LEFT;
                    frame_start = 1'b1;
                end
                LEFT: if (lrck_p1) begin
                    state_next  = RIGHT;
                    enter_right = 1'b1;
                end
                RIGHT: if (!lrck_p1) begin
                    state_next  = LEFT;
                    frame_start = 1'b1;
                end
                default: state_next = WAIT_SYNC;
            endcase
        end
    end

    // A flush overrides both ends: the push is lost and the pop sees empty
    assign fifo_empty = (fifo_level == '0);
    assign push       = write_audio_out & audio_out_allowed & ~clear_audio_out_memory;
    assign pop        = frame_start & ~fifo_empty & ~clear_audio_out_memory;
    assign rd_data    = mem[rd_ptr];

    // Next FIFO occupancy, net of a simultaneous push and pop
    always_comb begin
        level_next = fifo_level;
        if (clear_audio_out_memory) level_next = '0;
        else if (push && !pop)      level_next = fifo_level + LEVEL_ONE;
        else if (pop && !push)      level_next = fifo_level - LEVEL_ONE;
    end

    // FIFO control: pointers, level, back-pressure and underflow statistics
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            fifo_level        <= '0;
            audio_out_allowed <= 1'b0;
            underflow_count   <= 16'd0;
        end else begin
            if (clear_audio_out_memory) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level        <= level_next;
            audio_out_allowed <= (level_next != LEVEL_FULL);
            if (frame_start && !pop) underflow_count <= sat_inc16(underflow_count);
        end
    end

    // FIFO storage, {left, right} per entry
    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr] <= {left_channel_audio_out, right_channel_audio_out};
    end

    // Data bits shift on every fall inside the active part of a slot
    assign shift_en = bclk_fall & ~lr_edge & (state != WAIT_SYNC) & (bit_cnt < SLOT_BITS);

    // Sample path: the left word goes straight to the shifter at frame start,
    // the right word waits in hold_r until the LRCK 0->1 edge
    always_ff @(posedge CLOCK_50) begin
        if (frame_start) begin
            if (pop) begin
                shift_reg <= rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
                hold_r    <= rd_data[DATA_WIDTH-1:0];
            end else begin
                shift_reg <= '0;
                hold_r    <= '0;
            end
        end else if (enter_right) begin
            shift_reg <= hold_r;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Serial output: delay slot on the LRCK edge, then MSB..LSB, then zeros
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            bit_cnt    <= '0;
            AUD_DACDAT <= 1'b0;
        end else if (bclk_fall) begin
            if (lr_edge) begin
                bit_cnt    <= '0;
                AUD_DACDAT <= 1'b0;
            end else if (shift_en) begin
                bit_cnt    <= bit_cnt + 1'b1;
                AUD_DACDAT <= shift_reg[DATA_WIDTH-1];
            end else begin
                AUD_DACDAT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: directed frame vectors plus hand-written corner
// sequences for the I2S DAC serializer.
module tb_audio_dac_serializer;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        write_audio_out;
    logic        audio_out_allowed;
    logic        clear_audio_out_memory;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic [4:0]  fifo_level;
    logic [15:0] underflow_count;

    int tests = 0;
    int fails = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_dac_serializer #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(16),
        .ADDR_WIDTH(4)
    ) dut (
        .CLOCK_50               (CLOCK_50),
        .resetn                 (resetn),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .write_audio_out        (write_audio_out),
        .audio_out_allowed      (audio_out_allowed),
        .clear_audio_out_memory (clear_audio_out_memory),
        .AUD_BCLK               (AUD_BCLK),
        .AUD_DACLRCK            (AUD_DACLRCK),
        .AUD_DACDAT             (AUD_DACDAT),
        .fifo_level             (fifo_level),
        .underflow_count        (underflow_count)
    );

    typedef struct {
        logic        push;
        logic [31:0] l;
        logic [31:0] r;
        int          n;
        logic [63:0] exp_l;
        logic [63:0] exp_r;
        logic [15:0] exp_und;
    } frame_vec_t;

    frame_vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One BCLK period: fall (LRCK changes with it), optional one-cycle
    // push/clear pulse aligned with the DUT's fall detection, then rise and sample.
    task automatic bclk_bit(input logic lr, input logic pw, input logic clr,
                            input logic [31:0] pl, input logic [31:0] pr, output logic d);
        @(negedge CLOCK_50);
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = lr;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        if (pw) begin
            write_audio_out         = 1'b1;
            left_channel_audio_out  = pl;
            right_channel_audio_out = pr;
        end
        if (clr) clear_audio_out_memory = 1'b1;
        @(negedge CLOCK_50);
        write_audio_out        = 1'b0;
        clear_audio_out_memory = 1'b0;
        @(negedge CLOCK_50);
        AUD_BCLK = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        d = AUD_DACDAT;
    endtask

    // n BCLK periods at a fixed LRCK level; first bit ends up most significant in w
    task automatic half(input logic lr, input int n, input int pw_idx, input int clr_idx,
                        input logic [31:0] pl, input logic [31:0] pr, output logic [63:0] w);
        logic d;
        w = 64'h0;
        for (int i = 0; i < n; i++) begin
            bclk_bit(lr, (i == pw_idx), (i == clr_idx), pl, pr, d);
            w = {w[62:0], d};
        end
    endtask

    task automatic push_pair(input logic [31:0] l, input logic [31:0] r);
        @(negedge CLOCK_50);
        write_audio_out         = 1'b1;
        left_channel_audio_out  = l;
        right_channel_audio_out = r;
        @(negedge CLOCK_50);
        write_audio_out = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] wl, wr;

        // 64 fs frames with LSB truncation, silent frames, 72 fs and 40 fs frames
        vecs[0] = '{1'b0, 32'h0, 32'h0, 32, 64'h0, 64'h0, 16'd1};
        vecs[1] = '{1'b0, 32'h0, 32'h0, 32, 64'h0, 64'h0, 16'd2};
        vecs[2] = '{1'b0, 32'h0, 32'h0, 32, 64'h0, 64'h0, 16'd3};
        vecs[3] = '{1'b1, 32'hA5000001, 32'h80000000, 32, 64'h52800000, 64'h40000000, 16'd3};
        vecs[4] = '{1'b1, 32'h12345678, 32'hDEADBEEF, 36, 64'h91A2B3C0, 64'h6F56DF778, 16'd3};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 20, 64'h7FFFF, 64'h0, 16'd3};

        resetn                  = 1'b0;
        write_audio_out         = 1'b0;
        clear_audio_out_memory  = 1'b0;
        left_channel_audio_out  = 32'h0;
        right_channel_audio_out = 32'h0;
        AUD_BCLK                = 1'b1;
        AUD_DACLRCK             = 1'b1;

        repeat (3) @(negedge CLOCK_50);
        check("rst_dacdat", 64'(AUD_DACDAT), 64'h0);
        check("rst_allowed", 64'(audio_out_allowed), 64'h0);
        check("rst_level", 64'(fifo_level), 64'h0);
        check("rst_underflow", 64'(underflow_count), 64'h0);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        check("allowed_after_release", 64'(audio_out_allowed), 64'h1);

        // Right half while unsynchronised: no output
        half(1'b1, 32, -1, -1, 32'h0, 32'h0, wl);
        check("wait_sync_quiet", wl, 64'h0);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].push) begin
                push_pair(vecs[v].l, vecs[v].r);
                check($sformatf("vec%0d_level_push", v), 64'(fifo_level), 64'h1);
            end
            half(1'b0, vecs[v].n, -1, -1, 32'h0, 32'h0, wl);
            half(1'b1, vecs[v].n, -1, -1, 32'h0, 32'h0, wr);
            check($sformatf("vec%0d_left", v), wl, vecs[v].exp_l);
            check($sformatf("vec%0d_right", v), wr, vecs[v].exp_r);
            check($sformatf("vec%0d_underflow", v), 64'(underflow_count), 64'(vecs[v].exp_und));
            check($sformatf("vec%0d_level", v), 64'(fifo_level), 64'h0);
        end

        // 17 back-to-back pushes with BCLK idle
        for (int k = 0; k < 17; k++) begin
            @(negedge CLOCK_50);
            if (k == 15) check("allowed_before_16th", 64'(audio_out_allowed), 64'h1);
            if (k == 16) check("allowed_after_16th", 64'(audio_out_allowed), 64'h0);
            write_audio_out         = 1'b1;
            left_channel_audio_out  = 32'h100 + 32'(k);
            right_channel_audio_out = 32'h200 + 32'(k);
        end
        @(negedge CLOCK_50);
        write_audio_out = 1'b0;
        check("full_level", 64'(fifo_level), 64'd16);
        check("full_allowed", 64'(audio_out_allowed), 64'h0);
        for (int k = 0; k < 16; k++) begin
            half(1'b0, 33, -1, -1, 32'h0, 32'h0, wl);
            half(1'b1, 33, -1, -1, 32'h0, 32'h0, wr);
            check($sformatf("drain%0d_left", k), wl, 64'(32'h100 + 32'(k)));
            check($sformatf("drain%0d_right", k), wr, 64'(32'h200 + 32'(k)));
            if (k == 0) begin
                check("drain_level_15", 64'(fifo_level), 64'd15);
                check("drain_allowed_back", 64'(audio_out_allowed), 64'h1);
            end
        end
        half(1'b0, 33, -1, -1, 32'h0, 32'h0, wl);
        half(1'b1, 33, -1, -1, 32'h0, 32'h0, wr);
        check("pair17_not_sent_l", wl, 64'h0);
        check("pair17_not_sent_r", wr, 64'h0);
        check("pair17_underflow", 64'(underflow_count), 64'd4);

        // Push on the same cycle as the frame-start pop with one pair held
        push_pair(32'hCAFEF00D, 32'h0BADBEEF);
        half(1'b0, 33, 0, -1, 32'h13579BDF, 32'h2468ACE0, wl);
        check("pushpop_level", 64'(fifo_level), 64'h1);
        half(1'b1, 33, -1, -1, 32'h0, 32'h0, wr);
        check("pushpop_old_l", wl, 64'hCAFEF00D);
        check("pushpop_old_r", wr, 64'h0BADBEEF);
        check("pushpop_underflow", 64'(underflow_count), 64'd4);
        half(1'b0, 33, -1, -1, 32'h0, 32'h0, wl);
        half(1'b1, 33, -1, -1, 32'h0, 32'h0, wr);
        check("pushpop_new_l", wl, 64'h13579BDF);
        check("pushpop_new_r", wr, 64'h2468ACE0);

        // Flush mid-left-slot with five pairs queued
        for (int k = 0; k < 5; k++) push_pair(32'h55AA0000 + 32'(k), 32'h33CC0000 + 32'(k));
        check("clear_level_5", 64'(fifo_level), 64'd5);
        half(1'b0, 33, -1, 10, 32'h0, 32'h0, wl);
        check("clear_level_0", 64'(fifo_level), 64'h0);
        half(1'b1, 33, -1, -1, 32'h0, 32'h0, wr);
        check("clear_cur_l", wl, 64'h55AA0000);
        check("clear_cur_r", wr, 64'h33CC0000);
        half(1'b0, 33, -1, -1, 32'h0, 32'h0, wl);
        half(1'b1, 33, -1, -1, 32'h0, 32'h0, wr);
        check("clear_next_l", wl, 64'h0);
        check("clear_next_r", wr, 64'h0);
        check("clear_underflow", 64'(underflow_count), 64'd5);

        // Reset mid-right-slot
        push_pair(32'hFFFFFFFF, 32'hFFFFFFFF);
        half(1'b0, 33, -1, -1, 32'h0, 32'h0, wl);
        check("rstmid_left", wl, 64'hFFFFFFFF);
        half(1'b1, 10, -1, -1, 32'h0, 32'h0, wr);
        check("rstmid_partial_r", wr, 64'h1FF);
        check("rstmid_dacdat_before", 64'(AUD_DACDAT), 64'h1);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        #1;
        check("rstmid_dacdat", 64'(AUD_DACDAT), 64'h0);
        check("rstmid_underflow", 64'(underflow_count), 64'h0);
        check("rstmid_level", 64'(fifo_level), 64'h0);
        repeat (3) @(negedge CLOCK_50);
        resetn = 1'b1;
        push_pair(32'h0F0F0F0F, 32'hF0F0F0F0);
        half(1'b1, 22, -1, -1, 32'h0, 32'h0, wr);
        check("rstmid_rest_quiet", wr, 64'h0);
        check("rstmid_no_pop", 64'(fifo_level), 64'h1);
        half(1'b0, 33, -1, -1, 32'h0, 32'h0, wl);
        half(1'b1, 33, -1, -1, 32'h0, 32'h0, wr);
        check("rstmid_resume_l", wl, 64'h0F0F0F0F);
        check("rstmid_resume_r", wr, 64'hF0F0F0F0);
        check("rstmid_resume_und", 64'(underflow_count), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
